// File: rtl/cbus2apb.sv
// cbus2apb: single-outstanding CBUS slave to APB3/APB4 master bridge.
// Define CBUS2APB_TIMEOUT_EN to abort APB accesses stuck in wait states.
module cbus2apb #(
    parameter int          ADDRW    = 8,
    parameter int          TOUT_W   = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic             cbus_s_clk,
    input  logic             cbus_s_rst_n,
    input  logic             cbus_s_req,
    input  logic             cbus_s_cmd,
    input  logic [ADDRW-1:0] cbus_s_address,
    input  logic [31:0]      cbus_s_wdata,
    input  logic [3:0]       cbus_s_byten,
    input  logic [9:0]       cbus_s_bytecnt,
    input  logic             cbus_s_first,
    input  logic             cbus_s_last,
    output logic [31:0]      cbus_s_rdatap,
    output logic             cbus_s_rresp,
    output logic             cbus_s_waccept,
    output logic             cbus_s_err,
    output logic [ADDRW-1:0] apb_paddr,
    output logic             apb_psel,
    output logic             apb_penable,
    output logic             apb_pwrite,
    output logic [31:0]      apb_pwdata,
    output logic [3:0]       apb_pstrb,
    input  logic [31:0]      apb_prdata,
    input  logic             apb_pready,
    input  logic             apb_pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic [ADDRW-1:0]   paddr_q, paddr_d;
    logic [31:0]        pwdata_q, pwdata_d, rdatap_q, rdatap_d;
    logic [3:0]         pstrb_q, pstrb_d;
    logic               pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
    logic               rresp_q, rresp_d, waccept_q, waccept_d, err_q, err_d;
    logic               cap, legal, timeout;

    assign cap   = state_q == IDLE && cbus_s_req;
    assign legal = cbus_s_first && cbus_s_last && cbus_s_bytecnt == 10'd4;

`ifdef CBUS2APB_TIMEOUT_EN
    logic [TOUT_W-1:0] cnt_q, cnt_d;
    assign timeout = cnt_q == '1;
    assign cnt_d   = state_d == SETUP ? '0
                   : (state_q == ACCESS && !apb_pready) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge cbus_s_clk or negedge cbus_s_rst_n)
        if (!cbus_s_rst_n) cnt_q <= '0;
        else               cnt_q <= cnt_d;
`else
    logic [TOUT_W-1:0] tout_unused;
    assign tout_unused = '0;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cbus_s_req) state_d = legal ? SETUP : RESP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb_pready || timeout) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        paddr_d   = cap ? cbus_s_address : paddr_q;
        pwrite_d  = cap ? !cbus_s_cmd : pwrite_q;
        pwdata_d  = cap ? cbus_s_wdata : pwdata_q;
        pstrb_d   = cap ? (cbus_s_cmd ? 4'h0 : cbus_s_byten) : pstrb_q;
        psel_d    = state_d == SETUP || state_d == ACCESS;
        penable_d = state_d == ACCESS;
        rresp_d   = state_d == RESP && !pwrite_d;
        waccept_d = state_d == RESP && pwrite_d;
        err_d     = state_d == RESP && (state_q == IDLE || !apb_pready || apb_pslverr);
        rdatap_d  = rresp_d ? (err_d ? ERR_DATA : apb_prdata) : rdatap_q;
    end

    always_ff @(posedge cbus_s_clk or negedge cbus_s_rst_n)
        if (!cbus_s_rst_n) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rresp_q   <= 1'b0;
            waccept_q <= 1'b0;
            err_q     <= 1'b0;
            rdatap_q  <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rresp_q   <= rresp_d;
            waccept_q <= waccept_d;
            err_q     <= err_d;
            rdatap_q  <= rdatap_d;
        end

    assign apb_paddr      = paddr_q;
    assign apb_pwrite     = pwrite_q;
    assign apb_pwdata     = pwdata_q;
    assign apb_pstrb      = pstrb_q;
    assign apb_psel       = psel_q;
    assign apb_penable    = penable_q;
    assign cbus_s_rresp   = rresp_q;
    assign cbus_s_waccept = waccept_q;
    assign cbus_s_err     = err_q;
    assign cbus_s_rdatap  = rdatap_q;
endmodule

// File: tb/tb_cbus2apb.sv
// tb_cbus2apb: randomized self-checking bench for cbus2apb against a per-transaction timing model.
module tb_cbus2apb;
    localparam int          TW  = 4;
    localparam int          LIM = (1 << TW) - 1;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 0, rst_n = 0;
    logic        req = 0, cmd = 0, first = 0, last = 0;
    logic [7:0]  addr = 0;
    logic [31:0] wdata = 0, prdata = 0;
    logic [3:0]  byten = 0;
    logic [9:0]  bytecnt = 0;
    logic        pready = 0, pslverr = 0;
    logic [31:0] rdatap, pwdata;
    logic        rresp, waccept, err, psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [3:0]  pstrb;

    int          vecs = 0, errs = 0;
    logic [31:0] last_rd = 0;

    always #5 clk = ~clk;

    cbus2apb #(.ADDRW(8), .TOUT_W(TW), .ERR_DATA(ERR)) dut (
        .cbus_s_clk(clk), .cbus_s_rst_n(rst_n), .cbus_s_req(req), .cbus_s_cmd(cmd),
        .cbus_s_address(addr), .cbus_s_wdata(wdata), .cbus_s_byten(byten),
        .cbus_s_bytecnt(bytecnt), .cbus_s_first(first), .cbus_s_last(last),
        .cbus_s_rdatap(rdatap), .cbus_s_rresp(rresp), .cbus_s_waccept(waccept),
        .cbus_s_err(err), .apb_paddr(paddr), .apb_psel(psel), .apb_penable(penable),
        .apb_pwrite(pwrite), .apb_pwdata(pwdata), .apb_pstrb(pstrb),
        .apb_prdata(prdata), .apb_pready(pready), .apb_pslverr(pslverr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_apb(input logic c, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be);
        check("paddr", paddr, a);
        check("pwrite", pwrite, !c);
        check("pwdata", pwdata, wd);
        check("pstrb", pstrb, c ? 4'h0 : be);
    endtask

    // One CBUS request; called at posedge+1 with the bus idle, returns the same way.
    // waits = ACCESS cycles with pready low before the slave answers.
    task automatic txn(input logic c, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic [9:0] bc, input logic fi, input logic la, input int waits,
                       input logic se, input logic [31:0] rd);
        bit   legal, tout, e;
        int   r;
        legal = fi && la && bc == 10'd4;
`ifdef CBUS2APB_TIMEOUT_EN
        tout = legal && waits > LIM;
`else
        tout = 0;
`endif
        r = !legal ? 1 : tout ? LIM + 3 : waits + 3;
        e = !legal || tout || se;
        req = 1; cmd = c; addr = a; wdata = wd; byten = be; bytecnt = bc; first = fi; last = la;
        @(posedge clk); #1;
        for (int k = 1; k <= r + 1; k++) begin
            pready  = (k == waits + 2) && k < r;
            pslverr = se;
            prdata  = rd;
            if (k < r) begin
                check("psel", psel, 1);
                check("penable", penable, k >= 2);
                check("early_rresp", rresp, 0);
                check("early_waccept", waccept, 0);
                if (k == 1 || k == r - 1) check_apb(c, a, wd, be);
            end else if (k == r) begin
                check("resp_psel", psel, 0);
                check("resp_penable", penable, 0);
                check("rresp", rresp, c);
                check("waccept", waccept, !c);
                check("err", err, e);
                if (c) last_rd = e ? ERR : rd;
                check("rdatap", rdatap, last_rd);
                req = 0;
            end else begin
                check("post_rresp", rresp, 0);
                check("post_waccept", waccept, 0);
                check("post_psel", psel, 0);
                check("hold_rdatap", rdatap, last_rd);
            end
            @(posedge clk); #1;
        end
        pready = 0; pslverr = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rresp", rresp, 0);
        check("rst_waccept", waccept, 0);
        check("rst_err", err, 0);
        check("rst_rdatap", rdatap, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        rst_n = 1;
        @(posedge clk); #1;

        txn(1, 8'h10, 32'h0, 4'hF, 10'd4, 1, 1, 0, 0, 32'h1234_5678);
        txn(0, 8'h20, 32'hA5A5_0F0F, 4'h3, 10'd4, 1, 1, 3, 0, 32'h0);
        txn(1, 8'h30, 32'h0, 4'hF, 10'd4, 1, 1, 1, 1, 32'h5555_AAAA);
        txn(1, 8'h40, 32'h0, 4'hF, 10'd8, 1, 1, 0, 0, 32'h0);
        txn(0, 8'h44, 32'h1, 4'h1, 10'd4, 1, 0, 0, 0, 32'h0);
        txn(0, 8'h48, 32'h2, 4'hC, 10'd4, 1, 1, 2, 1, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [9:0]  bc;
            logic        fi, la;
            kind = $urandom_range(0, 7);
            bc   = kind == 0 ? 10'd8 : 10'd4;
            la   = kind != 1;
            fi   = kind != 2;
            txn($urandom_range(0, 1), 8'($urandom), $urandom, 4'($urandom), bc, fi, la,
                $urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom);
        end

`ifdef CBUS2APB_TIMEOUT_EN
        txn(1, 8'h50, 32'h0, 4'hF, 10'd4, 1, 1, LIM + 5, 0, 32'h0BAD_0BAD);
        txn(1, 8'h54, 32'h0, 4'hF, 10'd4, 1, 1, LIM, 0, 32'h600D_600D);
        txn(0, 8'h58, 32'h7, 4'h7, 10'd4, 1, 1, LIM - 1, 0, 32'h0);
`else
        txn(1, 8'h50, 32'h0, 4'hF, 10'd4, 1, 1, LIM + 5, 0, 32'h0BAD_0BAD);
`endif

        // Reset in the middle of an ACCESS phase.
        req = 1; cmd = 1; addr = 8'h60; byten = 4'hF; bytecnt = 10'd4; first = 1; last = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_penable", penable, 1);
        #2 rst_n = 0;
        #1;
        check("arst_psel", psel, 0);
        check("arst_penable", penable, 0);
        req = 0;
        last_rd = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("arst_rresp", rresp, 0);
            check("arst_waccept", waccept, 0);
        end
        check("arst_rdatap", rdatap, 0);
        rst_n = 1;
        @(posedge clk); #1;
        txn(1, 8'h64, 32'h0, 4'hF, 10'd4, 1, 1, 1, 0, 32'hCAFE_F00D);
        txn(0, 8'h68, 32'h9, 4'h9, 10'd4, 1, 1, 0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/cbus2apb.md
# cbus2apb

CBUS-slave to APB-master bridge: accepts single-beat CBUS read/write requests from a CBUS master and replays each one as one APB3/APB4 transfer toward a peripheral register file. Responses go back on the CBUS response signals: `cbus_s_rresp`/`cbus_s_rdatap` for reads, `cbus_s_waccept` for writes. One transaction is outstanding at a time. Optionally, an APB access that never completes is aborted by a timeout.

## Interface
Parameters:
- ADDRW, 8: address width on both buses.
- TOUT_W, 8: timeout counter width. The limit is 2^TOUT_W-1 wait cycles.
- ERR_DATA, 32'hDEAD_BEEF: value driven on `cbus_s_rdatap` for a read that ends in error.

Ports:
- cbus_s_clk, in, 1: clock; all logic is single-clock on cbus_s_clk.
- cbus_s_rst_n, in, 1: reset, asynchronous, active-low.
- cbus_s_req, in, 1: request; held by the master until its response is seen.
- cbus_s_cmd, in, 1: 1=read, 0=write.
- cbus_s_address, in, ADDRW: byte address.
- cbus_s_wdata, in, 32: write data.
- cbus_s_byten, in, 4: byte enables.
- cbus_s_bytecnt, in, 10: transfer byte count.
- cbus_s_first, in, 1: first beat.
- cbus_s_last, in, 1: last beat.
- cbus_s_rdatap, out, 32: read data, valid with cbus_s_rresp.
- cbus_s_rresp, out, 1: read response, one-cycle pulse.
- cbus_s_waccept, out, 1: write accept, one-cycle pulse.
- cbus_s_err, out, 1: error flag, valid with rresp/waccept.
- apb_paddr, out, ADDRW: APB address.
- apb_psel, out, 1: APB select.
- apb_penable, out, 1: APB enable.
- apb_pwrite, out, 1: APB write.
- apb_pwdata, out, 32: APB write data.
- apb_pstrb, out, 4: APB write strobes; equals byten on writes, 0 on reads.
- apb_prdata, in, 32: APB read data.
- apb_pready, in, 1: APB ready.
- apb_pslverr, in, 1: APB slave error.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- Reset values: state=IDLE; apb_psel, apb_penable, apb_pwrite, cbus_s_rresp, cbus_s_waccept and cbus_s_err =0; apb_paddr, apb_pwdata, apb_pstrb and cbus_s_rdatap =0.
- IDLE:
  - On cbus_s_req=1, capture address, cmd, wdata and byten.
  - Legal request (first=1, last=1, bytecnt=4): go to SETUP.
  - Any other request: go to RESP with err=1; no APB access is made.
- SETUP: psel=1, penable=0. Always goes to ACCESS next cycle.
- ACCESS: psel=1, penable=1.
  - On apb_pready=1, capture prdata and pslverr, then go to RESP.
  - Otherwise stay, incrementing the wait counter.
- RESP: one cycle, then IDLE.
  - Read: rresp=1. rdatap = captured prdata, or ERR_DATA if err=1.
  - Write: waccept=1.
  - err = pslverr, timeout, or illegal request.
  - psel and penable are 0 in RESP.
- Response pulses are exactly one cycle. In RESP, rdatap holds its value until the next read response.
- The master drops req in the cycle after the response. IDLE therefore always follows RESP, so the same request is never relaunched.
- apb_paddr, apb_pwrite, apb_pwdata and apb_pstrb stay stable from SETUP through ACCESS. They hold their last value in IDLE.
- req dropping mid-transfer (protocol violation) is ignored: the APB transfer completes and the response is still issued.
- Reset asserted mid-transfer aborts immediately: psel and penable go low asynchronously and no response is issued.

## Timing
- Request sampled in IDLE at cycle 0:
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS.
  - pready=1 in cycle 2 puts rresp/waccept in cycle 3, then IDLE in cycle 4.
- Minimum latency is 3 cycles from req to response; the minimum request period is 4 cycles.
- Each pready=0 cycle in ACCESS adds one cycle of latency.
- Illegal request: response in cycle 1.
- Timeout counter (TOUT_W bits):
  - Cleared on entering SETUP; increments per ACCESS cycle with pready=0.
  - When the counter equals 2^TOUT_W-1 and pready=0: drop psel/penable, go to RESP with err=1.
  - pready=1 in the limit cycle completes normally; no error is flagged.

## Configuration
- CBUS2APB_TIMEOUT_EN defined: the timeout counter and abort path exist as described above.
- Undefined: no counter is instantiated and ACCESS waits for pready indefinitely. cbus_s_err then reflects only pslverr and illegal requests.

## Test plan
- Read addr 8'h10, pready=1 immediately, prdata=32'h1234_5678 -> psel in cycle 1, penable in cycle 2, rresp=1 with rdatap=32'h1234_5678 in cycle 3, err=0.
- Write addr 8'h20, wdata=32'hA5A5_0F0F, byten=4'h3, pready after 3 wait cycles -> pstrb=4'h3 and pwrite=1 stable through ACCESS, waccept in cycle 6, err=0.
- Read with pslverr=1 -> rresp=1, err=1, rdatap=32'hDEAD_BEEF.
- Request with bytecnt=8 or last=0 -> psel stays 0, response pulse in cycle 1 with err=1.
- With CBUS2APB_TIMEOUT_EN and TOUT_W=4, pready held 0 -> abort after 15 wait cycles, err=1. A second run with pready=1 in the 15th wait cycle -> normal completion.
- Assert cbus_s_rst_n low in ACCESS -> psel and penable go to 0 immediately, no response, next request after reset completes normally.
